// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes, transaction ids
// and the slave FSM state encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_MEM,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_RESP
    } state_e;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word SRAM: synchronous read with one cycle of latency and a
// per-byte write enable. Read-during-write returns the old word.
module sram_1rw_be #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            en,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // NOTE: the array has no reset on purpose; it maps onto block RAM and its
    // contents must survive a bus reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DW/8; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a word-organised SRAM. One transaction is
// in flight at a time; simultaneous read/write requests alternate.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_AW;

    state_e            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic              in_range_q, in_range_d;
    logic [3:0]        rid_q, rid_d;
    logic [3:0]        bid_q, bid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic              bvalid_q, bvalid_d;
    logic              wready_q, wready_d;

    logic [31:0] ar_off, aw_off;
    logic        ar_in_range, aw_in_range;
    logic        grant_rd, grant_wr;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    // Unsigned wrap makes addresses below the base land far out of range.
    assign ar_off      = araddr - BASE_ADDR;
    assign aw_off      = awaddr - BASE_ADDR;
    assign ar_in_range = ar_off < MEM_BYTES;
    assign aw_in_range = aw_off < MEM_BYTES;

    assign grant_rd = arvalid && (!awvalid || last_wr_q);
    assign grant_wr = awvalid && !grant_rd;

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        rid_d      = rid_q;
        bid_d      = bid_q;
        rresp_d    = rresp_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        bvalid_d   = bvalid_q;
        wready_d   = wready_q;
        arready    = 1'b0;
        awready    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    arready    = 1'b1;
                    rid_d      = arid;
                    idx_d      = ar_off[MEM_AW+1:2];
                    in_range_d = ar_in_range;
                    rresp_d    = ar_in_range ? RESP_OKAY : RESP_DECERR;
                    state_d    = ST_RD_MEM;
                end else if (grant_wr) begin
                    awready    = 1'b1;
                    bid_d      = awid;
                    idx_d      = aw_off[MEM_AW+1:2];
                    in_range_d = aw_in_range;
                    bresp_d    = aw_in_range ? RESP_OKAY : RESP_DECERR;
                    wready_d   = 1'b1;
                    state_d    = ST_WR_DATA;
                end
            end
            ST_RD_MEM: begin
                mem_en   = in_range_q;
                rvalid_d = 1'b1;
                state_d  = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    last_wr_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (wvalid) begin
                    mem_en   = in_range_q;
                    mem_we   = in_range_q ? wstrb : 4'b0000;
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    last_wr_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_wr_q  <= 1'b1;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            rid_q      <= '0;
            bid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            rid_q      <= rid_d;
            bid_q      <= bid_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            bvalid_q   <= bvalid_d;
            wready_q   <= wready_d;
        end
    end

    sram_1rw_be #(
        .AW (MEM_AW),
        .DW (32)
    ) u_sram (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    // The SRAM output only moves when enabled, so rdata holds under backpressure.
    assign rdata   = (rvalid_q && in_range_q) ? mem_rdata : 32'h0;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;
    assign wready  = wready_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed cases plus randomized traffic
// checked against a word-array reference model.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int          MEM_AW = 12;
    localparam logic [31:0] BASE   = 32'h1fc0_0000;

    logic        clk;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        rd_q[$];
    exp_t        wr_q[$];
    logic [31:0] ref_mem [int];
    int          grants[$];
    int          both_high = 0;
    bit          arb_mode  = 0;
    bit          rand_bp   = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < (32'd4 << MEM_AW);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    // Reference model: writes merge enabled bytes into the word array.
    function automatic exp_t model_write(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s, input logic [3:0] id);
        exp_t e;
        logic [31:0] w;
        e.id   = id;
        e.data = 32'h0;
        if (addr_ok(a)) begin
            w = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
            for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[word_of(a)] = w;
            e.resp = RESP_OKAY;
        end else begin
            e.resp = RESP_DECERR;
        end
        return e;
    endfunction

    function automatic exp_t model_read(input logic [31:0] a, input logic [3:0] id);
        exp_t e;
        e.id = id;
        if (addr_ok(a)) begin
            e.resp = RESP_OKAY;
            e.data = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
        end else begin
            e.resp = RESP_DECERR;
            e.data = 32'h0;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever a response handshake is seen.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rvalid && rready) begin
                if (rd_q.size() == 0) check("unexpected_r", 32'(rvalid), 32'h0);
                else begin
                    e = rd_q.pop_front();
                    check("rid",   32'(rid),   32'(e.id));
                    check("rresp", 32'(rresp), 32'(e.resp));
                    check("rdata", rdata,      e.data);
                    check("rlast", 32'(rlast), 32'h1);
                end
            end
            if (bvalid && bready) begin
                if (wr_q.size() == 0) check("unexpected_b", 32'(bvalid), 32'h0);
                else begin
                    e = wr_q.pop_front();
                    check("bid",   32'(bid),   32'(e.id));
                    check("bresp", 32'(bresp), 32'(e.resp));
                end
            end
            if (arready && awready) both_high++;
            if (arb_mode) begin
                if (arvalid && arready) grants.push_back(0);
                if (awvalid && awready) grants.push_back(1);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) begin
            rready = ($urandom_range(0, 3) != 0);
            bready = ($urandom_range(0, 3) != 0);
        end
    end

    // sel: 0 AR, 1 AW, 2 W, 3 R handshake, 4 B handshake, 5 rvalid alone.
    // Returns on the posedge completing the handshake (+1), n = negedges waited.
    task automatic wait_hs(input int sel, input string name, output int n);
        bit hit;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = arvalid && arready;
                1:       hit = awvalid && awready;
                2:       hit = wvalid && wready;
                3:       hit = rvalid && rready;
                4:       hit = bvalid && bready;
                default: hit = rvalid;
            endcase
            if (hit) begin
                if (sel != 5) begin
                    @(posedge clk);
                    #1;
                end
                return;
            end
        end
        check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] id, input bit lat);
        int n;
        wr_q.push_back(model_write(a, d, s, id));
        awaddr = a; awid = id; awvalid = 1'b1;
        wait_hs(1, "aw", n);
        awvalid = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_hs(2, "w", n);
        if (lat) check("wready_latency", 32'(n), 32'h1);
        wvalid = 1'b0;
        wait_hs(4, "b", n);
        if (lat) check("b_latency", 32'(n), 32'h1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input bit lat);
        int n;
        rd_q.push_back(model_read(a, id));
        araddr = a; arid = id; arvalid = 1'b1;
        wait_hs(0, "ar", n);
        arvalid = 1'b0;
        wait_hs(3, "r", n);
        if (lat) check("r_latency", 32'(n), 32'h2);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    logic [31:0] pool_in  [8] = '{32'h1fc0_0000, 32'h1fc0_0004, 32'h1fc0_0008, 32'h1fc0_0010,
                                  32'h1fc0_0020, 32'h1fc0_0030, 32'h1fc0_0ffc, 32'h1fc0_3ffc};
    logic [31:0] pool_out [5] = '{32'h0000_0000, 32'h1fc0_4000, 32'h1fbf_fffc,
                                  32'hffff_fffc, 32'h1fc1_0000};

    initial begin
        int n;
        logic [31:0] a, d, hold_data;
        logic [3:0]  hold_id;
        exp_t        e;

        reset = 1'b1;
        arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready",  32'(wready),  32'h0);
        check("rst_rvalid",  32'(rvalid),  32'h0);
        check("rst_bvalid",  32'(bvalid),  32'h0);
        check("rst_rid",     32'(rid),     32'h0);
        check("rst_bid",     32'(bid),     32'h0);
        check("rst_rdata",   rdata,        32'h0);
        check("rst_rresp",   32'(rresp),   32'h0);
        check("rst_bresp",   32'(bresp),   32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full write and read-back with latency checks.
        do_write(32'h1fc0_0010, 32'hdead_beef, 4'hf, ID_DATA, 1'b1);
        do_read(32'h1fc0_0010, ID_INST, 1'b1);

        // Byte-enable merge and an all-zero strobe.
        do_write(32'h1fc0_0020, 32'h1122_3344, 4'hf, ID_DATA, 1'b0);
        do_write(32'h1fc0_0020, 32'h0000_ab00, 4'b0010, ID_DATA, 1'b0);
        do_read(32'h1fc0_0020, ID_DATA, 1'b0);
        do_write(32'h1fc0_0020, 32'hffff_ffff, 4'b0000, ID_DATA, 1'b0);
        do_read(32'h1fc0_0020, ID_DATA, 1'b0);

        // Initialise every in-range pool word.
        foreach (pool_in[i]) do_write(pool_in[i], $urandom, 4'hf, ID_DATA, 1'b0);

        // Out-of-range reads/writes leave memory untouched.
        do_read(32'h0000_0000, ID_INST, 1'b0);
        do_write(32'h1fc1_0000, 32'h5a5a_5a5a, 4'hf, ID_DATA, 1'b0);
        do_read(32'h1fc0_0000, ID_INST, 1'b0);
        do_read(32'h1fc0_4000, ID_DATA, 1'b0);
        do_read(32'h1fc0_3ffe, ID_DATA, 1'b0);

        // Backpressure: response held stable, no new grants.
        rready = 1'b0;
        e = model_read(32'h1fc0_0008, ID_DATA);
        rd_q.push_back(e);
        araddr = 32'h1fc0_0008; arid = ID_DATA; arvalid = 1'b1;
        wait_hs(0, "bp_ar", n);
        arvalid = 1'b0;
        wait_hs(5, "bp_rvalid", n);
        @(posedge clk);
        #1;
        araddr = 32'h1fc0_0000; arvalid = 1'b1;
        awaddr = 32'h1fc0_0004; awvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_rvalid",  32'(rvalid),  32'h1);
            check("bp_rdata",   rdata,        e.data);
            check("bp_rid",     32'(rid),     32'(e.id));
            check("bp_arready", 32'(arready), 32'h0);
            check("bp_awready", 32'(awready), 32'h0);
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0; awvalid = 1'b0; rready = 1'b1;
        wait_hs(3, "bp_r", n);

        // Arbitration from reset with both requests held.
        pulse_reset();
        rd_q.push_back(model_read(32'h1fc0_0010, ID_INST));
        rd_q.push_back(model_read(32'h1fc0_0010, ID_INST));
        wr_q.push_back(model_write(32'h1fc0_0030, 32'h0bad_cafe, 4'hf, ID_DATA));
        wr_q.push_back(model_write(32'h1fc0_0030, 32'h0bad_cafe, 4'hf, ID_DATA));
        arb_mode = 1'b1;
        araddr = 32'h1fc0_0010; arid = ID_INST; arvalid = 1'b1;
        awaddr = 32'h1fc0_0030; awid = ID_DATA; awvalid = 1'b1;
        wdata = 32'h0bad_cafe; wstrb = 4'hf; wvalid = 1'b1;
        for (int c = 0; c < 200 && grants.size() < 4; c++) @(negedge clk);
        @(posedge clk);
        #1;
        arvalid = 1'b0; awvalid = 1'b0;
        for (int c = 0; c < 200 && (rd_q.size() != 0 || wr_q.size() != 0); c++) @(posedge clk);
        #1;
        wvalid = 1'b0;
        arb_mode = 1'b0;
        check("arb_grants", 32'(grants.size()), 32'h4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));

        // Reset in WR_DATA drops the write.
        awaddr = 32'h1fc0_0004; awid = ID_DATA; awvalid = 1'b1;
        wait_hs(1, "rst_aw", n);
        awvalid = 1'b0;
        @(negedge clk);
        check("mid_wready", 32'(wready), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_wready_clr", 32'(wready),  32'h0);
        check("mid_bvalid",     32'(bvalid),  32'h0);
        check("mid_rvalid",     32'(rvalid),  32'h0);
        check("mid_arready",    32'(arready), 32'h0);
        check("mid_awready",    32'(awready), 32'h0);
        @(posedge clk);
        #1;
        do_read(32'h1fc0_0010, ID_INST, 1'b1);
        do_read(32'h1fc0_0004, ID_DATA, 1'b0);

        // Randomized traffic with random backpressure.
        rand_bp = 1'b1;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 4) == 0) a = pool_out[$urandom_range(0, 4)];
            else a = pool_in[$urandom_range(0, 7)];
            a[1:0] = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 1)), 1'b0);
            else
                do_read(a, 4'($urandom_range(0, 1)), 1'b0);
        end
        rand_bp = 1'b0;
        rready = 1'b1; bready = 1'b1;
        repeat (5) @(posedge clk);

        check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'h0);
        check("ready_overlap",  32'(both_high),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
